mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_access_wb_mux.sv | 25 ++
 rtl/mem_access.sv | 139 +++++++++++++
 tb/tb_mem_access.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared pipeline definitions: writeback-select and MEM-stage FSM encodings,
// the bus error fill value and the load decode helper.
package mem_access_pkg;

    typedef enum logic [1:0] {
        WSEL_ALU = 2'b00,
        WSEL_RAM = 2'b01,
        WSEL_PC4 = 2'b10,
        WSEL_EXT = 2'b11
    } wsel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    // A load is a register write whose value comes from the data bus.
    function automatic logic is_load(input logic rf_we, input logic [1:0] wsel);
        return rf_we && (wsel == WSEL_RAM);
    endfunction

endpackage

// File: rtl/mem_access_wb_mux.sv
// Combinational writeback value selector for the MEM/WB boundary.
module wb_mux
    import mem_access_pkg::*;
(
    input  logic [1:0]  wsel,
    input  logic [31:0] alu_c,
    input  logic [31:0] ram_data,
    input  logic [31:0] pc4,
    input  logic [31:0] ext,
    output logic [31:0] wd
);

    // Select the value that will be written back to the register file.
    always_comb begin
        wd = alu_c;
        case (wsel)
            WSEL_ALU: wd = alu_c;
            WSEL_RAM: wd = ram_data;
            WSEL_PC4: wd = pc4;
            WSEL_EXT: wd = ext;
            default:  wd = alu_c;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues load/store requests on the data bus, stalls the pipeline
// until ack or timeout, and registers the writeback values.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] ALU_C_MEM_in,
    input  logic [31:0] rD2_MEM_in,
    input  logic [31:0] pc4_MEM_in,
    input  logic [31:0] ext_MEM_in,
    input  logic        ram_we_MEM_in,
    input  logic        rf_we_MEM_in,
    input  logic [1:0]  rf_wsel_MEM_in,
    input  logic [4:0]  wR_MEM_in,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall,
    output logic [31:0] wD_WB_in,
    output logic [4:0]  wR_WB_in,
    output logic        rf_we_WB_in,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    mem_state_e  state_r;
    logic [7:0]  cnt_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic [31:0] wd_r;
    logic [4:0]  wr_r;
    logic        rf_we_r;
    logic        err_r;

    logic        store_s;
    logic        load_s;
    logic        access_s;
    logic        timeout_s;
    logic        done_s;
    logic        wb_we_s;
    logic [31:0] ram_data_s;
    logic [31:0] wd_s;

    assign store_s    = ram_we_MEM_in;
    assign load_s     = is_load(rf_we_MEM_in, rf_wsel_MEM_in);
    assign access_s   = store_s | load_s;
    assign timeout_s  = (state_r == ST_WAIT) && !bus_ack && (cnt_r == TIMEOUT_C);
    assign done_s     = (state_r == ST_WAIT) && (bus_ack || timeout_s);
    // A timed-out access substitutes the error pattern for the missing read data.
    assign ram_data_s = bus_ack ? bus_rdata : BUS_ERR_DATA;
    assign wb_we_s    = rf_we_MEM_in && !store_s && (wR_MEM_in != 5'd0);

    wb_mux u_wb_mux (
        .wsel     (rf_wsel_MEM_in),
        .alu_c    (ALU_C_MEM_in),
        .ram_data (ram_data_s),
        .pc4      (pc4_MEM_in),
        .ext      (ext_MEM_in),
        .wd       (wd_s)
    );

    // Stall during the capture cycle and every WAIT cycle that does not complete.
    always_comb begin
        mem_stall = 1'b0;
        if (state_r == ST_IDLE) begin
            mem_stall = access_s;
        end else begin
            mem_stall = !done_s;
        end
    end

    // Access FSM, wait counter, captured request and writeback registers.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            we_r    <= 1'b0;
            wd_r    <= 32'd0;
            wr_r    <= 5'd0;
            rf_we_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        addr_r  <= ALU_C_MEM_in;
                        wdata_r <= rD2_MEM_in;
                        we_r    <= store_s;
                        cnt_r   <= 8'd0;
                        wr_r    <= 5'd0;
                        rf_we_r <= 1'b0;
                        state_r <= ST_WAIT;
                    end else begin
                        wd_r    <= wd_s;
                        wr_r    <= wR_MEM_in;
                        rf_we_r <= rf_we_MEM_in && (wR_MEM_in != 5'd0);
                    end
                end
                ST_WAIT: begin
                    if (done_s) begin
                        wd_r    <= wd_s;
                        wr_r    <= wR_MEM_in;
                        rf_we_r <= wb_we_s;
                        err_r   <= err_r | timeout_s;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                        wr_r    <= 5'd0;
                        rf_we_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    assign bus_req     = (state_r == ST_WAIT);
    assign bus_addr    = addr_r;
    assign bus_wdata   = wdata_r;
    assign bus_we      = we_r;
    assign wD_WB_in    = wd_r;
    assign wR_WB_in    = wr_r;
    assign rf_we_WB_in = rf_we_r;
    assign bus_err     = err_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// accesses checked against a transaction-level model of the MEM stage.
module tb_mem_access;

    localparam int TO = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] alu_c, rd2, pc4, ext;
    logic        ram_we, rf_we;
    logic [1:0]  wsel;
    logic [4:0]  wr;
    logic        bus_req, bus_we, bus_ack, mem_stall, rf_we_wb, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, wd_wb;
    logic [4:0]  wr_wb;

    int   errors = 0;
    int   checks = 0;
    logic exp_err = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    mem_access #(.TIMEOUT(TO)) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .ALU_C_MEM_in   (alu_c),
        .rD2_MEM_in     (rd2),
        .pc4_MEM_in     (pc4),
        .ext_MEM_in     (ext),
        .ram_we_MEM_in  (ram_we),
        .rf_we_MEM_in   (rf_we),
        .rf_wsel_MEM_in (wsel),
        .wR_MEM_in      (wr),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_we         (bus_we),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .mem_stall      (mem_stall),
        .wD_WB_in       (wd_wb),
        .wR_WB_in       (wr_wb),
        .rf_we_WB_in    (rf_we_wb),
        .bus_err        (bus_err)
    );

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] a,
                                         input logic [31:0] r, input logic [31:0] p,
                                         input logic [31:0] e);
        logic [31:0] v [4];
        v[0] = a; v[1] = r; v[2] = p; v[3] = e;
        return v[s];
    endfunction

    task automatic nop();
        alu_c = 32'd0; rd2 = 32'd0; pc4 = 32'd0; ext = 32'd0;
        ram_we = 1'b0; rf_we = 1'b0; wsel = 2'b00; wr = 5'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
    endtask

    // Non-memory instruction; called just after an edge with the FSM idle.
    task automatic alu_op(input logic [1:0] s, input logic [31:0] a, input logic [31:0] p,
                          input logic [31:0] e, input logic [4:0] r, input logic we,
                          input string name);
        logic [31:0] exp_wd;
        alu_c = a; pc4 = p; ext = e; rd2 = $urandom; wsel = s; wr = r; rf_we = we;
        ram_we = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
        exp_wd = pick(s, a, 32'd0, p, e);
        #1;
        checks++;
        if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: stall=%b req=%b, required 0 0", name, mem_stall, bus_req);
        end
        @(posedge cpu_clk); #1;
        nop();
        checks++;
        if (wd_wb !== exp_wd || wr_wb !== r || rf_we_wb !== (we && r != 5'd0)) begin
            errors++;
            $display("FAIL %s wb: wd=%h wr=%0d we=%b, required %h %0d %b",
                     name, wd_wb, wr_wb, rf_we_wb, exp_wd, r, we && r != 5'd0);
        end
        checks++;
        if (bus_req !== 1'b0 || bus_err !== exp_err) begin
            errors++;
            $display("FAIL %s bus: req=%b err=%b, required 0 %b", name, bus_req, bus_err, exp_err);
        end
        #1;
    endtask

    // One load or store; delay = WAIT cycles without ack before ack (> TO means never).
    task automatic run_access(input logic st, input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] r, input int delay, input logic [31:0] rdata,
                              input string name);
        int   stalls, waits;
        logic done, exp_stall, timed_out;
        logic [31:0] wd_prev;
        wd_prev = wd_wb;
        alu_c = addr; rd2 = data; pc4 = $urandom; ext = $urandom; wr = r;
        ram_we = st; rf_we = !st; wsel = st ? 2'b00 : 2'b01;
        bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        checks++;
        if (mem_stall !== 1'b1 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s capture: stall=%b req=%b, required 1 0", name, mem_stall, bus_req);
        end
        stalls = 1; waits = 0; done = 1'b0;
        while (!done && waits < TO + 3) begin
            @(posedge cpu_clk); #1;
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== addr || bus_wdata !== data || bus_we !== st) begin
                errors++;
                $display("FAIL %s request: req=%b addr=%h wdata=%h we=%b, required 1 %h %h %b",
                         name, bus_req, bus_addr, bus_wdata, bus_we, addr, data, st);
            end
            checks++;
            if (rf_we_wb !== 1'b0 || wr_wb !== 5'd0 || wd_wb !== wd_prev) begin
                errors++;
                $display("FAIL %s bubble: we=%b wr=%0d wd=%h, required 0 0 %h",
                         name, rf_we_wb, wr_wb, wd_wb, wd_prev);
            end
            bus_ack = (waits == delay);
            bus_rdata = bus_ack ? rdata : $urandom;
            #1;
            exp_stall = !(waits == delay || waits == TO);
            checks++;
            if (mem_stall !== exp_stall) begin
                errors++;
                $display("FAIL %s wait%0d stall: got %b, required %b", name, waits, mem_stall, exp_stall);
            end
            if (mem_stall === 1'b1) stalls++;
            done = !exp_stall;
            waits++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s bound: access did not complete within %0d cycles", name, TO + 3);
        end
        @(posedge cpu_clk); #1;
        nop();
        timed_out = (delay > TO);
        exp_err = exp_err | timed_out;
        checks++;
        if (stalls != 1 + (timed_out ? TO : delay)) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, 1 + (timed_out ? TO : delay));
        end
        if (!st) begin
            checks++;
            if (wd_wb !== (timed_out ? 32'hDEADBEEF : rdata) || wr_wb !== r) begin
                errors++;
                $display("FAIL %s load_wb: wd=%h wr=%0d, required %h %0d",
                         name, wd_wb, wr_wb, timed_out ? 32'hDEADBEEF : rdata, r);
            end
        end
        checks++;
        if (rf_we_wb !== (!st && r != 5'd0) || bus_err !== exp_err || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s done: we=%b err=%b req=%b, required %b %b 0",
                     name, rf_we_wb, bus_err, bus_req, !st && r != 5'd0, exp_err);
        end
        #1;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b0;
        nop();
        repeat (3) @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b1;
        checks++;
        if (bus_req !== 1'b0 || mem_stall !== 1'b0 || wd_wb !== 32'd0 || wr_wb !== 5'd0 ||
            rf_we_wb !== 1'b0 || bus_err !== 1'b0 || bus_addr !== 32'd0 || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%b stall=%b wd=%h wr=%0d we=%b err=%b addr=%h, required all 0",
                     bus_req, mem_stall, wd_wb, wr_wb, rf_we_wb, bus_err, bus_addr);
        end
        #1;
    endtask

    task automatic test_alu();
        alu_op(2'b00, 32'h0000_1234, 32'h10, 32'h20, 5'd5, 1'b1, "alu_basic");
        alu_op(2'b10, 32'h1, 32'h0000_0044, 32'h3, 5'd31, 1'b1, "alu_pc4");
        alu_op(2'b11, 32'h1, 32'h2, 32'hFFFF_FF80, 5'd7, 1'b1, "alu_ext");
        alu_op(2'b00, 32'h55, 32'h2, 32'h3, 5'd0, 1'b1, "alu_r0");
        alu_op(2'b00, 32'h66, 32'h2, 32'h3, 5'd9, 1'b0, "alu_nowe");
    endtask

    task automatic test_load_delayed();
        run_access(1'b0, 32'h0000_2000, 32'h0, 5'd3, 3, 32'hCAFE0001, "load_delay3");
    endtask

    task automatic test_store();
        run_access(1'b1, 32'hFFFF_F000, 32'hA5A5A5A5, 5'd4, 0, 32'h0, "store_fast");
    endtask

    task automatic test_ack_at_timeout();
        run_access(1'b0, 32'h0000_3000, 32'h0, 5'd6, TO, 32'h1357_9BDF, "ack_at_timeout");
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h0000_4000, 32'h0, 5'd8, 1000, 32'h0, "load_timeout");
        alu_op(2'b00, 32'h77, 32'h0, 32'h0, 5'd2, 1'b1, "err_sticky");
    endtask

    task automatic test_reset_in_wait();
        alu_c = 32'h0000_5000; rd2 = 32'h0; wsel = 2'b01; rf_we = 1'b1; ram_we = 1'b0; wr = 5'd10;
        @(posedge cpu_clk); #1;
        @(posedge cpu_clk); #1;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait pre: req=%b, required 1", bus_req);
        end
        cpu_rst = 1'b0;
        nop();
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b1;
        exp_err = 1'b0;
        checks++;
        if (bus_req !== 1'b0 || mem_stall !== 1'b0 || wd_wb !== 32'd0 || wr_wb !== 5'd0 ||
            rf_we_wb !== 1'b0 || bus_err !== 1'b0 || bus_addr !== 32'd0 || bus_wdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_wait post: req=%b stall=%b wd=%h wr=%0d we=%b err=%b addr=%h, required all 0",
                     bus_req, mem_stall, wd_wb, wr_wb, rf_we_wb, bus_err, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'h8765_4321;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait late_ack stall: got %b, required 0", mem_stall);
        end
        @(posedge cpu_clk); #1;
        bus_ack = 1'b0;
        checks++;
        if (bus_req !== 1'b0 || rf_we_wb !== 1'b0 || wd_wb !== 32'd0) begin
            errors++;
            $display("FAIL rst_wait late_ack: req=%b we=%b wd=%h, required 0 0 0", bus_req, rf_we_wb, wd_wb);
        end
        #1;
    endtask

    task automatic test_load_r0();
        run_access(1'b0, 32'h0000_6000, 32'h0, 5'd0, 1, 32'h2468_ACE0, "load_r0");
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 32'h0000_7000, 32'h0, 5'd11, 0, 32'h1111_2222, "b2b_0");
        run_access(1'b1, 32'h0000_7004, 32'h3333_4444, 5'd0, 2, 32'h0, "b2b_1");
        run_access(1'b0, 32'h0000_7008, 32'h0, 5'd12, 1, 32'h5555_6666, "b2b_2");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [1:0] s;
            logic [4:0] r;
            kind = $urandom_range(0, 2);
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if (kind == 0) begin
                s = 2'($urandom);
                if (s == 2'b01) s = 2'b10;
                alu_op(s, $urandom, $urandom, $urandom, r, 1'($urandom), "rand_alu");
            end else begin
                run_access(kind == 2, $urandom, $urandom, r, $urandom_range(0, TO + 2),
                           $urandom, kind == 2 ? "rand_store" : "rand_load");
            end
        end
    endtask

    initial begin
        nop();
        cpu_rst = 1'b0;
        @(posedge cpu_clk); #1;
        test_reset();
        test_alu();
        test_load_delayed();
        test_store();
        test_ack_at_timeout();
        test_timeout();
        test_reset_in_wait();
        test_load_r0();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
